// File: rtl/mccu_if.sv
// mccu_if: control bundle between the multi-cycle control unit and its datapath.
//   Decode inputs : op, func (instruction fields), z (ALU zero flag)
//   Memory        : mem_ready (input), mem_req / iord / wmem (outputs)
//   Datapath      : irwrite, pcwrite, pcsource, alusrca, alusrcb, aluc,
//                   sext, shift, wreg, regrt, m2reg, jal
//   Status pulses : illegal, bus_err, done
// master = control unit side, slave = datapath side.
interface mccu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       wmem;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic       sext;
    logic       shift;
    logic       wreg;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       illegal;
    logic       bus_err;
    logic       done;

    modport master (
        input  op, func, z, mem_ready,
        output mem_req, iord, wmem, irwrite, pcwrite, pcsource, alusrca,
               alusrcb, aluc, sext, shift, wreg, regrt, m2reg, jal,
               illegal, bus_err, done
    );

    modport slave (
        output op, func, z, mem_ready,
        input  mem_req, iord, wmem, irwrite, pcwrite, pcsource, alusrca,
               alusrcb, aluc, sext, shift, wreg, regrt, m2reg, jal,
               illegal, bus_err, done
    );
endinterface

// File: rtl/mccu_fsm.sv
// mccu_fsm: multi-cycle control unit for a shared single-ALU / single-memory
// MIPS-subset datapath. Steps each instruction through IF/ID/EXE/MEM/WB and
// drives every datapath enable. Memory accesses use a ready handshake; a run
// of WAIT_LIMIT unanswered wait cycles raises bus_err and retries the fetch.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active high; forces all outputs to 0
//   bus  - mccu_if.master: op/func/z/mem_ready in, all control signals out
// Outputs are decoded combinationally from the registered state, the
// instruction fields, z and mem_ready so the datapath sees them in the same
// cycle the memory answers.
module mccu_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int CW         = 4
) (
    input  logic   clk,
    input  logic   rst,
    mccu_if.master bus
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   wait_cnt_r;
    logic [CW-1:0]   next_cnt_s;

    // decoded instruction class
    logic       legal_s, rtype_s, itype_s, lw_s, sw_s, beq_s, bne_s;
    logic       j_s, jal_s, jr_s, jalr_s, shift_op_s, isext_s;
    logic [3:0] alu_op_s;

    // control values before being driven onto the interface
    logic       mem_req_s, iord_s, wmem_s, irwrite_s, pcwrite_s;
    logic [1:0] pcsource_s, alusrcb_s;
    logic       alusrca_s, sext_s, shift_s, wreg_s, regrt_s, m2reg_s, jal_s_o;
    logic [3:0] aluc_s;
    logic       illegal_s, bus_err_s, done_s;
    logic       timeout_s;

    // Instruction decode: classify op/func and pick the ALU operation.
    always_comb begin
        legal_s    = 1'b1;
        rtype_s    = 1'b0;
        itype_s    = 1'b0;
        lw_s       = 1'b0;
        sw_s       = 1'b0;
        beq_s      = 1'b0;
        bne_s      = 1'b0;
        j_s        = 1'b0;
        jal_s      = 1'b0;
        jr_s       = 1'b0;
        jalr_s     = 1'b0;
        shift_op_s = 1'b0;
        isext_s    = 1'b0;
        alu_op_s   = 4'b0000;
        case (bus.op)
            6'b000000: begin
                case (bus.func)
                    6'b100000: begin rtype_s = 1'b1; alu_op_s = 4'b0000; end // add
                    6'b100010: begin rtype_s = 1'b1; alu_op_s = 4'b0100; end // sub
                    6'b100100: begin rtype_s = 1'b1; alu_op_s = 4'b0001; end // and
                    6'b100101: begin rtype_s = 1'b1; alu_op_s = 4'b0101; end // or
                    6'b100110: begin rtype_s = 1'b1; alu_op_s = 4'b0010; end // xor
                    6'b100111: begin rtype_s = 1'b1; alu_op_s = 4'b1101; end // nor
                    6'b101010: begin rtype_s = 1'b1; alu_op_s = 4'b1000; end // slt
                    6'b000000: begin rtype_s = 1'b1; alu_op_s = 4'b0011; shift_op_s = 1'b1; end // sll
                    6'b000010: begin rtype_s = 1'b1; alu_op_s = 4'b0111; shift_op_s = 1'b1; end // srl
                    6'b000011: begin rtype_s = 1'b1; alu_op_s = 4'b1111; shift_op_s = 1'b1; end // sra
                    6'b001000: jr_s   = 1'b1;
                    6'b001001: jalr_s = 1'b1;
                    default:   legal_s = 1'b0;
                endcase
            end
            6'b001000: begin itype_s = 1'b1; alu_op_s = 4'b0000; isext_s = 1'b1; end // addi
            6'b001100: begin itype_s = 1'b1; alu_op_s = 4'b0001; end                 // andi
            6'b001101: begin itype_s = 1'b1; alu_op_s = 4'b0101; end                 // ori
            6'b001110: begin itype_s = 1'b1; alu_op_s = 4'b0010; end                 // xori
            6'b001111: begin itype_s = 1'b1; alu_op_s = 4'b0110; end                 // lui
            6'b001010: begin itype_s = 1'b1; alu_op_s = 4'b1000; isext_s = 1'b1; end // slti
            6'b100011: lw_s  = 1'b1;
            6'b101011: sw_s  = 1'b1;
            6'b000100: beq_s = 1'b1;
            6'b000101: bne_s = 1'b1;
            6'b000010: j_s   = 1'b1;
            6'b000011: jal_s = 1'b1;
            default:   legal_s = 1'b0;
        endcase
    end

    // The wait budget is exhausted only when memory still has not answered.
    assign timeout_s = (wait_cnt_r == CW'(WAIT_LIMIT)) && !bus.mem_ready;

    // Per-state control outputs and next-state / wait-counter computation.
    always_comb begin
        mem_req_s    = 1'b0;
        iord_s       = 1'b0;
        wmem_s       = 1'b0;
        irwrite_s    = 1'b0;
        pcwrite_s    = 1'b0;
        pcsource_s   = 2'b00;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        aluc_s       = 4'b0000;
        sext_s       = 1'b0;
        shift_s      = 1'b0;
        wreg_s       = 1'b0;
        regrt_s      = 1'b0;
        m2reg_s      = 1'b0;
        jal_s_o      = 1'b0;
        illegal_s    = 1'b0;
        bus_err_s    = 1'b0;
        done_s       = 1'b0;
        next_state_s = state_r;
        next_cnt_s   = wait_cnt_r;
        if (rst) begin
            // everything held at 0 while reset is asserted
            next_state_s = S_IF;
            next_cnt_s   = '0;
        end else begin
            case (state_r)
                S_IF: begin
                    if (bus.mem_ready) begin
                        // fetch completes: load IR and advance PC to PC+4
                        mem_req_s    = 1'b1;
                        irwrite_s    = 1'b1;
                        pcwrite_s    = 1'b1;
                        alusrcb_s    = 2'b01;
                        aluc_s       = 4'b0000;
                        pcsource_s   = 2'b00;
                        next_state_s = S_ID;
                        next_cnt_s   = '0;
                    end else if (timeout_s) begin
                        // give up this access; PC untouched so the fetch retries
                        bus_err_s    = 1'b1;
                        next_state_s = S_IF;
                        next_cnt_s   = '0;
                    end else begin
                        mem_req_s    = 1'b1;
                        next_cnt_s   = wait_cnt_r + CW'(1);
                    end
                end
                S_ID: begin
                    // ALU computes the branch target PC+(imm<<2) for EXE
                    alusrcb_s  = 2'b11;
                    sext_s     = 1'b1;
                    aluc_s     = 4'b0000;
                    next_cnt_s = '0;
                    if (!legal_s) begin
                        illegal_s    = 1'b1;
                        next_state_s = S_IF;
                    end else if (j_s || jal_s) begin
                        pcwrite_s    = 1'b1;
                        pcsource_s   = 2'b11;
                        wreg_s       = jal_s;
                        jal_s_o      = jal_s;
                        done_s       = 1'b1;
                        next_state_s = S_IF;
                    end else if (jr_s || jalr_s) begin
                        pcwrite_s    = 1'b1;
                        pcsource_s   = 2'b10;
                        wreg_s       = jalr_s;
                        jal_s_o      = jalr_s;
                        done_s       = 1'b1;
                        next_state_s = S_IF;
                    end else begin
                        next_state_s = S_EXE;
                    end
                end
                S_EXE: begin
                    next_cnt_s = '0;
                    alusrca_s  = 1'b1;
                    if (beq_s || bne_s) begin
                        // xor of rs/rt drives z; PC takes latched target when taken
                        alusrcb_s    = 2'b00;
                        aluc_s       = 4'b0010;
                        pcwrite_s    = (beq_s && bus.z) || (bne_s && !bus.z);
                        pcsource_s   = 2'b01;
                        done_s       = 1'b1;
                        next_state_s = S_IF;
                    end else if (lw_s || sw_s) begin
                        alusrcb_s    = 2'b10;
                        sext_s       = 1'b1;
                        aluc_s       = 4'b0000;
                        next_state_s = S_MEM;
                    end else if (rtype_s) begin
                        alusrcb_s    = 2'b00;
                        aluc_s       = alu_op_s;
                        shift_s      = shift_op_s;
                        next_state_s = S_WB;
                    end else begin
                        alusrcb_s    = 2'b10;
                        aluc_s       = alu_op_s;
                        sext_s       = isext_s;
                        next_state_s = S_WB;
                    end
                end
                S_MEM: begin
                    iord_s = 1'b1;
                    if (bus.mem_ready) begin
                        mem_req_s  = 1'b1;
                        wmem_s     = sw_s;
                        next_cnt_s = '0;
                        if (sw_s) begin
                            done_s       = 1'b1;
                            next_state_s = S_IF;
                        end else begin
                            // MDR captures the load data on this edge
                            next_state_s = S_WB;
                        end
                    end else if (timeout_s) begin
                        bus_err_s    = 1'b1;
                        next_state_s = S_IF;
                        next_cnt_s   = '0;
                    end else begin
                        mem_req_s  = 1'b1;
                        wmem_s     = sw_s;
                        next_cnt_s = wait_cnt_r + CW'(1);
                    end
                end
                S_WB: begin
                    wreg_s       = 1'b1;
                    regrt_s      = itype_s || lw_s;
                    m2reg_s      = lw_s;
                    done_s       = 1'b1;
                    next_cnt_s   = '0;
                    next_state_s = S_IF;
                end
                default: begin
                    next_state_s = S_IF;
                    next_cnt_s   = '0;
                end
            endcase
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IF;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= next_cnt_s;
        end
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.iord     = iord_s;
    assign bus.wmem     = wmem_s;
    assign bus.irwrite  = irwrite_s;
    assign bus.pcwrite  = pcwrite_s;
    assign bus.pcsource = pcsource_s;
    assign bus.alusrca  = alusrca_s;
    assign bus.alusrcb  = alusrcb_s;
    assign bus.aluc     = aluc_s;
    assign bus.sext     = sext_s;
    assign bus.shift    = shift_s;
    assign bus.wreg     = wreg_s;
    assign bus.regrt    = regrt_s;
    assign bus.m2reg    = m2reg_s;
    assign bus.jal      = jal_s_o;
    assign bus.illegal  = illegal_s;
    assign bus.bus_err  = bus_err_s;
    assign bus.done     = done_s;

endmodule

// File: tb/tb_mccu_fsm.sv
// tb_mccu_fsm: directed self-checking bench for mccu_fsm. Inputs change one
// time unit after each rising edge and outputs are sampled one unit later.
module tb_mccu_fsm;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;

    mccu_if bus ();

    mccu_fsm #(.WAIT_LIMIT(15), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] ctrl_vec();
        return {bus.mem_req, bus.iord, bus.wmem, bus.irwrite, bus.pcwrite,
                bus.pcsource, bus.alusrca, bus.alusrcb, bus.aluc, bus.sext,
                bus.shift, bus.wreg, bus.regrt, bus.m2reg, bus.jal,
                bus.illegal, bus.bus_err, bus.done};
    endfunction

    // set memory/zero inputs, then let the combinational outputs settle
    task automatic go(input logic rdy, input logic zz);
        bus.mem_ready = rdy;
        bus.z         = zz;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // zero-wait ALU instruction: IF, ID, EXE, WB
    task automatic run_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic [3:0] e_aluc, input logic e_shift,
                           input logic e_sext, input logic [1:0] e_srcb,
                           input logic e_regrt);
        bus.op   = op;
        bus.func = fn;
        go(1'b1, 1'b0);
        check({nm, "_if_irwrite"}, 32'(bus.irwrite), 32'd1);
        nxt(); go(1'b1, 1'b0);
        check({nm, "_id_done"}, 32'(bus.done), 32'd0);
        nxt(); go(1'b1, 1'b0);
        check({nm, "_exe_aluc"}, 32'(bus.aluc), 32'(e_aluc));
        check({nm, "_exe_shift"}, 32'(bus.shift), 32'(e_shift));
        check({nm, "_exe_sext"}, 32'(bus.sext), 32'(e_sext));
        check({nm, "_exe_srcb"}, 32'(bus.alusrcb), 32'(e_srcb));
        check({nm, "_exe_wreg"}, 32'(bus.wreg), 32'd0);
        nxt(); go(1'b1, 1'b0);
        check({nm, "_wb_wreg"}, 32'(bus.wreg), 32'd1);
        check({nm, "_wb_regrt"}, 32'(bus.regrt), 32'(e_regrt));
        check({nm, "_wb_done"}, 32'(bus.done), 32'd1);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        rst           = 1'b1;
        bus.op        = 6'b000000;
        bus.func      = 6'b100000;
        bus.z         = 1'b0;
        bus.mem_ready = 1'b1;
        nxt(); nxt(); go(1'b1, 1'b0);
        check("rst_outputs", 32'(ctrl_vec()), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'd0);
        rst = 1'b0;

        // add with the ready line held high: done on the 4th cycle
        go(1'b1, 1'b0);
        check("add_if_pcwrite", 32'(bus.pcwrite), 32'd1);
        check("add_if_srcb", 32'(bus.alusrcb), 32'd1);
        check("add_if_wreg", 32'(bus.wreg), 32'd0);
        nxt(); go(1'b1, 1'b0);
        check("add_id_srcb", 32'(bus.alusrcb), 32'd3);
        check("add_id_wreg", 32'(bus.wreg), 32'd0);
        nxt(); go(1'b1, 1'b0);
        check("add_exe_srca", 32'(bus.alusrca), 32'd1);
        check("add_exe_wreg", 32'(bus.wreg), 32'd0);
        nxt(); go(1'b1, 1'b0);
        check("add_wb_wreg", 32'(bus.wreg), 32'd1);
        check("add_wb_regrt", 32'(bus.regrt), 32'd0);
        check("add_wb_done", 32'(bus.done), 32'd1);
        nxt();
        check("add_back_if", 32'(dut.state_r), 32'd0);

        run_alu("sub",  6'b000000, 6'b100010, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0);
        run_alu("sll",  6'b000000, 6'b000000, 4'b0011, 1'b1, 1'b0, 2'b00, 1'b0);
        run_alu("nor",  6'b000000, 6'b100111, 4'b1101, 1'b0, 1'b0, 2'b00, 1'b0);
        run_alu("ori",  6'b001101, 6'b000000, 4'b0101, 1'b0, 1'b0, 2'b10, 1'b1);
        run_alu("slti", 6'b001010, 6'b000000, 4'b1000, 1'b0, 1'b1, 2'b10, 1'b1);

        // lw with three wait cycles in MEM: done on cycle 8
        bus.op = 6'b100011;
        for (int c = 1; c <= 8; c++) begin
            go((c >= 4 && c <= 6) ? 1'b0 : 1'b1, 1'b0);
            check($sformatf("lw_c%0d_done", c), 32'(bus.done), (c == 8) ? 32'd1 : 32'd0);
            if (c >= 4 && c <= 7) begin
                check($sformatf("lw_c%0d_state", c), 32'(dut.state_r), 32'd3);
                check($sformatf("lw_c%0d_iord", c), 32'(bus.iord), 32'd1);
            end
            if (c == 8) begin
                check("lw_wb_m2reg", 32'(bus.m2reg), 32'd1);
                check("lw_wb_regrt", 32'(bus.regrt), 32'd1);
            end
            nxt();
        end

        // beq taken / not taken
        for (int t = 0; t < 2; t++) begin
            bus.op = 6'b000100;
            go(1'b1, 1'b0); nxt();
            go(1'b1, 1'b0); nxt();
            go(1'b1, (t == 0) ? 1'b1 : 1'b0);
            check($sformatf("beq%0d_pcwrite", t), 32'(bus.pcwrite), (t == 0) ? 32'd1 : 32'd0);
            check($sformatf("beq%0d_pcsource", t), 32'(bus.pcsource), 32'd1);
            check($sformatf("beq%0d_aluc", t), 32'(bus.aluc), 32'd2);
            check($sformatf("beq%0d_done", t), 32'(bus.done), 32'd1);
            nxt();
            check($sformatf("beq%0d_back_if", t), 32'(dut.state_r), 32'd0);
        end

        // jal finishes in ID
        bus.op = 6'b000011;
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0);
        check("jal_pcwrite", 32'(bus.pcwrite), 32'd1);
        check("jal_pcsource", 32'(bus.pcsource), 32'd3);
        check("jal_wreg", 32'(bus.wreg), 32'd1);
        check("jal_jal", 32'(bus.jal), 32'd1);
        check("jal_done", 32'(bus.done), 32'd1);
        nxt();
        check("jal_back_if", 32'(dut.state_r), 32'd0);

        // jr: PC from rs, no register write
        bus.op   = 6'b000000;
        bus.func = 6'b001000;
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0);
        check("jr_pcsource", 32'(bus.pcsource), 32'd2);
        check("jr_wreg", 32'(bus.wreg), 32'd0);
        check("jr_done", 32'(bus.done), 32'd1);
        nxt();

        // fetch timeout: 15 tolerated waits, bus_err on the next one
        for (int i = 0; i < 15; i++) begin
            go(1'b0, 1'b0);
            check($sformatf("wait%0d_bus_err", i), 32'(bus.bus_err), 32'd0);
            nxt();
        end
        go(1'b0, 1'b0);
        check("to_bus_err", 32'(bus.bus_err), 32'd1);
        check("to_mem_req", 32'(bus.mem_req), 32'd0);
        check("to_irwrite", 32'(bus.irwrite), 32'd0);
        check("to_pcwrite", 32'(bus.pcwrite), 32'd0);
        nxt();
        check("to_state_if", 32'(dut.state_r), 32'd0);
        go(1'b0, 1'b0);
        check("to_cnt_cleared", 32'(bus.bus_err), 32'd0);

        // illegal opcode after the refetch
        bus.op = 6'b111111;
        go(1'b1, 1'b0);
        check("refetch_irwrite", 32'(bus.irwrite), 32'd1);
        nxt(); go(1'b1, 1'b0);
        check("ill_op_illegal", 32'(bus.illegal), 32'd1);
        check("ill_op_wreg", 32'(bus.wreg), 32'd0);
        check("ill_op_pcwrite", 32'(bus.pcwrite), 32'd0);
        check("ill_op_wmem", 32'(bus.wmem), 32'd0);
        check("ill_op_done", 32'(bus.done), 32'd0);
        nxt();
        check("ill_op_back_if", 32'(dut.state_r), 32'd0);

        // undefined R-type function code
        bus.op   = 6'b000000;
        bus.func = 6'b111111;
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0);
        check("ill_fn_illegal", 32'(bus.illegal), 32'd1);
        nxt();

        // sw interrupted by reset while waiting in MEM
        bus.op = 6'b101011;
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0);
        check("sw_exe_srcb", 32'(bus.alusrcb), 32'd2);
        nxt(); go(1'b0, 1'b0);
        check("sw_mem_wmem", 32'(bus.wmem), 32'd1);
        rst = 1'b1;
        #1;
        check("sw_rst_wmem", 32'(bus.wmem), 32'd0);
        check("sw_rst_outputs", 32'(ctrl_vec()), 32'd0);
        nxt();
        check("sw_rst_state", 32'(dut.state_r), 32'd0);
        rst = 1'b0;

        // sw with zero wait completes in MEM on cycle 4
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0); nxt();
        go(1'b1, 1'b0);
        check("sw4_wmem", 32'(bus.wmem), 32'd1);
        check("sw4_done", 32'(bus.done), 32'd1);
        nxt();
        check("sw4_back_if", 32'(dut.state_r), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
